// File: rtl/bus_responder.sv
// Responder for the 8-bit multiplexed four-phase handshake bus.
// Decodes addr-low / addr-high / data beats and serves them from a flop-array memory with a side-load port.
module bus_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic                 rd_i,
  input  logic                 wr_i,
  output logic                 ack_o,
  input  logic [7:0]           bus_i,
  output logic [7:0]           bus_o,
  output logic                 bus_oe_o,
  input  logic                 ld_en,
  input  logic [ADDR_BITS-1:0] ld_addr,
  input  logic [7:0]           ld_data,
  output logic [15:0]          last_addr_o,
  output logic                 txn_done_o,
  output logic                 err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACKED} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] req_sync;
  logic                   req_s;
  logic [1:0]             beat;
  logic [3:0]             wcnt;
  logic [15:0]            addr;
  logic                   mode_rd;
  logic                   mode_wr;
  logic                   mode_err;
  logic [7:0]             mem [DEPTH];
  logic [ADDR_BITS-1:0]   idx;
  logic                   commit_c;
  logic                   mem_we_c;

  assign req_s    = req_sync[SYNC_STAGES-1];
  assign idx      = addr[ADDR_BITS-1:0];
  assign commit_c = (state == S_WAIT) && (wcnt == 4'd0);
  assign mem_we_c = commit_c && (beat == 2'd2) && mode_wr && !mode_rd;

  // Request synchroniser for the asynchronous initiator strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_sync <= '0;
    else        req_sync <= {req_sync[SYNC_STAGES-2:0], req_i};
  end

  // Memory is not reset; a bus write issued last overrides a same-address side load
  always_ff @(posedge clk) begin
    if (ld_en)    mem[ld_addr] <= ld_data;
    if (mem_we_c) mem[idx]     <= bus_i;
  end

  // Handshake FSM with beat tracking and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      beat        <= 2'd0;
      wcnt        <= 4'd0;
      addr        <= 16'd0;
      mode_rd     <= 1'b0;
      mode_wr     <= 1'b0;
      mode_err    <= 1'b0;
      ack_o       <= 1'b0;
      bus_o       <= 8'd0;
      bus_oe_o    <= 1'b0;
      last_addr_o <= 16'd0;
      txn_done_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      txn_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_s) begin
            state <= S_WAIT;
            wcnt  <= 4'(WAIT_CYCLES);
            if (beat == 2'd0) begin
              mode_rd  <= rd_i;
              mode_wr  <= wr_i;
              mode_err <= (rd_i == wr_i);
              if (rd_i == wr_i) err_o <= 1'b1;
            end
            // Read data is placed on the bus before ack rises
            if ((beat == 2'd2) && mode_rd) begin
              bus_oe_o <= 1'b1;
              bus_o    <= mode_err ? 8'hFF : mem[idx];
            end
          end
        end
        S_WAIT: begin
          if (wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
          end else begin
            state <= S_ACKED;
            ack_o <= 1'b1;
            case (beat)
              2'd0: addr[7:0]  <= bus_i;
              2'd1: addr[15:8] <= bus_i;
              2'd2: begin
                last_addr_o <= addr;
                txn_done_o  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_ACKED: begin
          if (!req_s) begin
            state    <= S_IDLE;
            ack_o    <= 1'b0;
            bus_oe_o <= 1'b0;
            beat     <= (beat == 2'd2) ? 2'd0 : 2'(beat + 2'd1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Target end of the 8-bit multiplexed handshake bus driven by the CPU core's memory interface.
- Decodes the three-beat transaction (address low, address high, data) and answers with a four-phase ack.
- Serves reads and writes from an internal flop-array memory.
- Used as the companion memory in FPGA/bench builds; a side load port allows program preload.

Parameters:
- ADDR_BITS, 8, number of low address bits decoding the memory (DEPTH = 2**ADDR_BITS); upper address bits are ignored for access.
- WAIT_CYCLES, 0, extra cycles inserted between request detection and ack rise (0..15).
- SYNC_STAGES, 2, flops in the req_i synchroniser (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  1  initiator strobe (initiator handshake out); asynchronous, synchronised internally
- rd_i  in  1  initiator read qualifier; stable for the whole transaction
- wr_i  in  1  initiator write qualifier; stable for the whole transaction
- ack_o  out  1  responder acknowledge (initiator handshake in); registered
- bus_i  in  8  shared bus, input path
- bus_o  out  8  shared bus, output path (read data)
- bus_oe_o  out  1  drive enable for bus_o; registered
- ld_en  in  1  side-load write strobe
- ld_addr  in  ADDR_BITS  side-load address
- ld_data  in  8  side-load data
- last_addr_o  out  16  full 16-bit address of the last completed transaction
- txn_done_o  out  1  one-cycle pulse at data-beat commit
- err_o  out  1  sticky protocol error flag

Behaviour:
- Reset values: ack_o=0, bus_oe_o=0, bus_o=0, last_addr_o=0, txn_done_o=0, err_o=0, beat=0, state IDLE, synchroniser cleared. Memory contents are not reset.
- req_s is req_i after SYNC_STAGES flops. rd_i, wr_i and bus_i are sampled only while req_s=1; they are guaranteed stable by then.
- Beat counter (2 bits) sequence: 0 = addr low, 1 = addr high, 2 = data. Value 3 is unreachable.
- State IDLE (ack_o=0):
  - On req_s=1, go to WAIT and load wcnt=WAIT_CYCLES.
  - On beat 0, latch mode from {rd_i,wr_i}.
  - On beat 2 with a read, set bus_o=mem[addr[ADDR_BITS-1:0]] and bus_oe_o=1 on the same edge.
- State WAIT:
  - While wcnt!=0, decrement it.
  - When wcnt=0, go to ACKED and set ack_o=1 on that edge.
  - With WAIT_CYCLES=0, ack_o rises exactly 1 cycle after req_s is first seen high.
- Commit happens on the edge ack_o rises:
  - Beat 0: addr[7:0]<=bus_i.
  - Beat 1: addr[15:8]<=bus_i.
  - Beat 2, write: mem[addr]<=bus_i, last_addr_o<=addr, txn_done_o=1 for one cycle.
  - Beat 2, read: last_addr_o<=addr, txn_done_o=1 (data already on bus).
- State ACKED (ack_o=1): hold ack_o and bus_o/bus_oe_o. On req_s=0, ack_o<=0, bus_oe_o<=0, beat<=beat+1 (2 wraps to 0), go to IDLE.
- A new request is never answered while ack_o=1. Four-phase ordering is strict.
- Mode error: {rd_i,wr_i} equal to 00 or 11 at beat 0.
  - err_o<=1 (sticky until reset).
  - The transaction is still acked through all 3 beats so the initiator never hangs.
  - No memory write occurs. A read-style data beat drives 0xFF.
- Side load: ld_en writes mem[ld_addr]<=ld_data in any state.
  - A same-cycle bus write to the same address wins.
  - A same-cycle bus write to a different address: both writes occur.
- Read-after-write: a bus read returns data committed by any earlier edge, including a side load one cycle before the read's IDLE->WAIT edge.
- Reset mid-transaction (rst_n low at any beat or state) returns to the reset values immediately, asynchronously: bus is released, beat=0, and a partially captured address is discarded.
- req_i glitch: a pulse shorter than the synchroniser window may be missed. That is legal only because the initiator holds req until ack.

Test Plan:
- WAIT_CYCLES=0, write to 0x1234 data 0x5A (beats 0x34, 0x12, 0x5A) -> ack_o rises 1 cycle after each req_s rise; mem[0x34]=0x5A; last_addr_o=0x1234; txn_done_o pulses once; err_o=0.
- Read 0x0034 after the above -> bus_oe_o=1 with bus_o=0x5A before ack_o rises on beat 2; released the cycle ack_o falls.
- WAIT_CYCLES=3, any beat -> ack_o rises 4 cycles after req_s; back-to-back transactions keep beat alignment (0,1,2,0).
- Side load mem[0x10]=0xC3, then bus read 0xFF10 -> returns 0xC3; last_addr_o=0xFF10. Simultaneous ld_en to 0x34 with 0x00 during a bus write of 0x77 to 0x34 -> mem[0x34]=0x77.
- rd_i=wr_i=1 at beat 0 -> err_o=1 stays set; all 3 beats acked; memory unchanged.
- Assert rst_n low while in ACKED on beat 1 -> ack_o=0, bus_oe_o=0 immediately. The next transaction starts at beat 0 and completes correctly.
